// File: rtl/rxdata_if.sv
// Bundle between the hex-word receiver and its neighbours: serial line in, decoded word out.
// Latency: none, wires only.
// Backpressure: none; the consumer must take stb on the cycle it is high.
interface rxdata_if;
  logic        uart_rx;  // asynchronous serial line, idles high
  logic        stb;      // one-cycle strobe: a complete word was decoded
  logic [31:0] data;     // last decoded word, held between strobes
  logic        err;      // one-cycle strobe: framing or syntax error

  // The receiver sources the decoded words.
  modport master (
    input  uart_rx,
    output stb,
    output data,
    output err
  );

  // The line driver / word consumer side.
  modport slave (
    output uart_rx,
    input  stb,
    input  data,
    input  err
  );
endinterface

// File: rtl/rxdata.sv
// Decodes "0x" + 8 hex digits + "\r\n" (or "\n") lines from an 8N1 serial line into 32-bit words.
// Latency: stb/err rise 1 clock after the stop-bit sample (2 sync clocks + baud timing from the pin).
// Backpressure: none; stb/err are single-cycle pulses.  Optional macro RXDATA_ERR_EN enables
// o_err pulses and stop-bit checking; without it err is tied low and every stop bit is accepted.
module rxdata #(
  parameter int CLOCKS_PER_BAUD = 1250
) (
  input  logic      i_clk,
  input  logic      i_reset,
  rxdata_if.master  bus
);

  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLOCKS_PER_BAUD - 1);

  localparam logic [7:0] CH_0    = 8'h30;  // '0'
  localparam logic [7:0] CH_X_LO = 8'h78;  // 'x'
  localparam logic [7:0] CH_X_UP = 8'h58;  // 'X'
  localparam logic [7:0] CH_CR   = 8'h0d;
  localparam logic [7:0] CH_LF   = 8'h0a;

  // ---------------------------------------------------------------------------
  // Bit-level 8N1 receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_WAIT,
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  logic [1:0]    rx_sync;
  logic          rx_s;
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          byte_vld, byte_vld_n;
  logic          frame_err, frame_err_n;
  logic [7:0]    byte_dat;

  // Two-flop synchronizer; resets low so RX_WAIT only leaves on a real idle-high line.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_sync <= 2'b00;
    end else begin
      rx_sync <= {rx_sync[0], bus.uart_rx};
    end
  end

  assign rx_s = rx_sync[1];

  // The shift register is only written in RX_DATA, so it is stable while byte_vld is high.
  assign byte_dat = rx_shift;

  // Bit receiver state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_state  <= RX_WAIT;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      rx_shift  <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_next;
      baud_cnt  <= baud_cnt_n;
      bit_idx   <= bit_idx_n;
      rx_shift  <= rx_shift_n;
      byte_vld  <= byte_vld_n;
      frame_err <= frame_err_n;
    end
  end

  // Bit receiver next-state: half-bit delay to the start-bit centre, then whole bits.
  always_comb begin
    rx_next     = rx_state;
    baud_cnt_n  = baud_cnt;
    bit_idx_n   = bit_idx;
    rx_shift_n  = rx_shift;
    byte_vld_n  = 1'b0;
    frame_err_n = 1'b0;
    case (rx_state)
      RX_WAIT: begin
        // Reset may have landed mid-byte; wait for the line to go idle first.
        if (rx_s) rx_next = RX_IDLE;
      end
      RX_IDLE: begin
        if (!rx_s) begin
          baud_cnt_n = HALF_LOAD;
          rx_next    = RX_START;
        end
      end
      RX_START: begin
        if (baud_cnt == '0) begin
          if (rx_s) begin
            // Line came back high before mid start bit: a glitch, not a byte.
            rx_next = RX_IDLE;
          end else begin
            baud_cnt_n = FULL_LOAD;
            bit_idx_n  = 3'd0;
            rx_next    = RX_DATA;
          end
        end else begin
          baud_cnt_n = baud_cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (baud_cnt == '0) begin
          rx_shift_n = {rx_s, rx_shift[7:1]};  // LSB arrives first
          baud_cnt_n = FULL_LOAD;
          if (bit_idx == 3'd7) begin
            rx_next = RX_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (baud_cnt == '0) begin
          // Back to idle right at mid stop bit so the next start edge is not missed.
          rx_next = RX_IDLE;
`ifdef RXDATA_ERR_EN
          if (rx_s) begin
            byte_vld_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
`else
          byte_vld_n = 1'b1;
`endif
        end else begin
          baud_cnt_n = baud_cnt - 1'b1;
        end
      end
      default: rx_next = RX_WAIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Character parser
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    P_IDLE,
    P_ZERO,
    P_HEX,
    P_END,
    P_CR
  } p_state_t;

  p_state_t    p_state, p_next;
  logic [31:0] hex_shift, hex_shift_n;
  logic [3:0]  hex_cnt, hex_cnt_n;
  logic        stb_q, stb_n;
  logic [31:0] data_q, data_n;
  logic        syntax_err;
  logic [4:0]  hex_nib;  // {is_hex, value}

  // ASCII hex digit to nibble; letters map via their low nibble plus 9.
  function automatic logic [4:0] hex_val(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

  assign hex_nib = hex_val(byte_dat);

  // Parser state and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      p_state   <= P_IDLE;
      hex_shift <= '0;
      hex_cnt   <= '0;
      stb_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      p_state   <= p_next;
      hex_shift <= hex_shift_n;
      hex_cnt   <= hex_cnt_n;
      stb_q     <= stb_n;
      data_q    <= data_n;
    end
  end

  // Parser next-state: advances once per accepted byte; framing errors drop the word.
  always_comb begin
    p_next      = p_state;
    hex_shift_n = hex_shift;
    hex_cnt_n   = hex_cnt;
    stb_n       = 1'b0;
    data_n      = data_q;
    syntax_err  = 1'b0;
    if (frame_err) begin
      p_next = P_IDLE;
    end else if (byte_vld) begin
      case (p_state)
        P_IDLE: begin
          // Stray bytes between words are ignored silently.
          if (byte_dat == CH_0) p_next = P_ZERO;
        end
        P_ZERO: begin
          if (byte_dat == CH_X_LO || byte_dat == CH_X_UP) begin
            p_next      = P_HEX;
            hex_shift_n = '0;
            hex_cnt_n   = '0;
          end else if (byte_dat != CH_0) begin
            syntax_err = 1'b1;
          end
        end
        P_HEX: begin
          if (hex_nib[4]) begin
            hex_shift_n = {hex_shift[27:0], hex_nib[3:0]};
            hex_cnt_n   = hex_cnt + 4'd1;
            if (hex_cnt == 4'd7) p_next = P_END;
          end else begin
            syntax_err = 1'b1;
          end
        end
        P_END: begin
          if (byte_dat == CH_LF) begin
            stb_n  = 1'b1;
            data_n = hex_shift;
            p_next = P_IDLE;
          end else if (byte_dat == CH_CR) begin
            p_next = P_CR;
          end else begin
            syntax_err = 1'b1;  // includes a ninth hex digit
          end
        end
        P_CR: begin
          if (byte_dat == CH_LF) begin
            stb_n  = 1'b1;
            data_n = hex_shift;
            p_next = P_IDLE;
          end else begin
            syntax_err = 1'b1;
          end
        end
        default: p_next = P_IDLE;
      endcase
      // An erroring '0' is likely the start of the next word, so resync straight into P_ZERO.
      if (syntax_err) p_next = (byte_dat == CH_0) ? P_ZERO : P_IDLE;
    end
  end

  assign bus.stb  = stb_q;
  assign bus.data = data_q;

`ifdef RXDATA_ERR_EN
  logic err_q;

  // Error pulse lands on the same edge a strobe would have.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= frame_err | (byte_vld & syntax_err);
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
